master_slave_jk_ff: RTL and testbench

Master-slave JK flip-flop bank: WIDTH independent JK bits, each built as a master register followed by a slave register. The master stage samples the JK next-state on the rising clock edge. The slave stage transfers the master value to the output on the following falling edge. It is a general-purpose storage/toggle primitive for control logic and counters that need the classic half-cycle output delay of a master-slave device.

---
 rtl/master_slave_jk_ff_if.sv | 29 ++
 rtl/master_slave_jk_ff.sv | 43 ++++
 tb/tb_master_slave_jk_ff.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/master_slave_jk_ff_if.sv
// Bus bundle for the master-slave JK flip-flop bank: per-bit J/K in, slave/master state out.
`timescale 1ns/1ps
interface master_slave_jk_ff_if #(
  parameter int unsigned WIDTH = 1
) ();
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] qm;

  // Driver side: supplies J/K and observes the flip-flop state.
  modport master (
    output j,
    output k,
    input  q,
    input  qn,
    input  qm
  );

  // Flip-flop side: consumes J/K and presents slave, complement and master stages.
  modport slave (
    input  j,
    input  k,
    output q,
    output qn,
    output qm
  );
endinterface

// File: rtl/master_slave_jk_ff.sv
// Bank of WIDTH independent master-slave JK flip-flops: master loads on the rising
// edge from the current slave value, slave copies the master on the falling edge.
`timescale 1ns/1ps
module master_slave_jk_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  master_slave_jk_ff_if.slave bus
);

  logic [WIDTH-1:0] master_q;
  logic [WIDTH-1:0] master_d;
  logic [WIDTH-1:0] slave_q;

  // Next state is derived from the slave, which is stable through the high phase,
  // so a held J=K=1 toggles exactly once per clock period.
  always_comb begin
    master_d = (bus.j & ~slave_q) | (~bus.k & slave_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_q <= '0;
    end else begin
      master_q <= master_d;
    end
  end

  // Reset also clears the slave, discarding any master value not yet transferred.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      slave_q <= '0;
    end else begin
      slave_q <= master_q;
    end
  end

  assign bus.q  = slave_q;
  assign bus.qn = ~slave_q;
  assign bus.qm = master_q;

endmodule

// File: tb/tb_master_slave_jk_ff.sv
// Directed plus randomized bench for master_slave_jk_ff at WIDTH=1 and WIDTH=4.
`timescale 1ns/1ps
module tb_master_slave_jk_ff;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference state: what master and slave should hold.
  logic       m1q, m1qm;
  logic [3:0] m4q, m4qm;

  always #5 clk = ~clk;

  master_slave_jk_ff_if #(.WIDTH(1)) if1 ();
  master_slave_jk_ff_if #(.WIDTH(4)) if4 ();

  master_slave_jk_ff #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
  master_slave_jk_ff #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(if4));

  // JK behaviour as the textbook truth table: hold, reset, set, toggle.
  function automatic logic jk_rule(input logic j, input logic k, input logic q);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return !q;
    endcase
  endfunction

  function automatic logic [3:0] jk_vec(input logic [3:0] j, input logic [3:0] k,
                                        input logic [3:0] q);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = jk_rule(j[b], k[b], q[b]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q1"},   {3'b0, if1.q},  {3'b0, m1q});
    chk({tag, ".qn1"},  {3'b0, if1.qn}, {3'b0, ~m1q});
    chk({tag, ".qm1"},  {3'b0, if1.qm}, {3'b0, m1qm});
    chk({tag, ".q4"},   if4.q,  m4q);
    chk({tag, ".qn4"},  if4.qn, ~m4q);
    chk({tag, ".qm4"},  if4.qm, m4qm);
  endtask

  // One full clock: drive while clk is low, check master after rise, slave after fall.
  task automatic step(input string tag, input logic j1, input logic k1,
                      input logic [3:0] j4, input logic [3:0] k4);
    if1.j = j1; if1.k = k1;
    if4.j = j4; if4.k = k4;
    @(posedge clk); #1;
    m1qm = jk_rule(j1, k1, m1q);
    m4qm = jk_vec(j4, k4, m4q);
    chk_all({tag, ".rise"});
    @(negedge clk); #1;
    m1q = m1qm;
    m4q = m4qm;
    chk_all({tag, ".fall"});
  endtask

  // Reset pulse landing between a rising edge and the following falling edge.
  task automatic mid_reset(input string tag, input logic j1, input logic k1,
                           input logic [3:0] j4, input logic [3:0] k4);
    if1.j = j1; if1.k = k1;
    if4.j = j4; if4.k = k4;
    @(posedge clk); #1;
    m1qm = jk_rule(j1, k1, m1q);
    m4qm = jk_vec(j4, k4, m4q);
    chk_all({tag, ".rise"});
    #1 rst = 1'b1;
    #1;
    m1qm = 1'b0; m1q = 1'b0;
    m4qm = '0;   m4q = '0;
    chk_all({tag, ".rst"});
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk_all({tag, ".fall"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if1.j = 1'b1; if1.k = 1'b0;
    if4.j = 4'hF; if4.k = 4'h0;
    m1q = 1'b0; m1qm = 1'b0;
    m4q = '0;   m4qm = '0;

    // Reset holds everything clear, edges ignored even with J asserted.
    #1 chk_all("reset.t1");
    @(posedge clk); #1 chk_all("reset.rise");
    @(negedge clk); #1 chk_all("reset.fall");
    rst = 1'b0;
    if1.j = 1'b0; if1.k = 1'b0;
    if4.j = 4'h0; if4.k = 4'h0;
    chk_all("reset.release");
    @(posedge clk); #1 chk_all("post_reset.rise");
    #3 chk_all("post_reset.pre_fall");
    @(negedge clk); #1 chk_all("post_reset.fall");

    // Set, then reset function.
    step("set", 1'b1, 1'b0, 4'b0011, 4'b0000);
    chk("set.q_const", {3'b0, if1.q}, 4'b0001);
    chk("w4.prep_const", if4.q, 4'b0011);
    step("reset_fn", 1'b0, 1'b1, 4'b1010, 4'b0110);
    chk("reset_fn.q_const", {3'b0, if1.q}, 4'b0000);
    chk("w4.mix_const", if4.q, 4'b1001);

    // Toggle held four cycles, then hold three cycles.
    for (int i = 0; i < 4; i++) begin
      step("toggle", 1'b1, 1'b1, 4'hF, 4'hF);
      chk("toggle.seq_const", {3'b0, if1.q}, {3'b0, ~i[0]});
    end
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, 4'h0, 4'h0);
      chk("hold.q_const", {3'b0, if1.q}, 4'b0000);
    end

    // Mid-cycle reset discards a pending set.
    mid_reset("mid_rst", 1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("mid_rst.q_const", {3'b0, if1.q}, 4'b0000);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 60; i++) begin
      logic       rj1, rk1;
      logic [3:0] rj4, rk4;
      rj1 = 1'($urandom);
      rk1 = 1'($urandom);
      rj4 = 4'($urandom);
      rk4 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) mid_reset("rand_rst", rj1, rk1, rj4, rk4);
      else                           step("rand", rj1, rk1, rj4, rk4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
